// File: rtl/cbp_ue_enc.sv
// cbp_ue_enc
// Two-stage elastic pipeline for the coded_block_pattern syntax element.
// Stage 1 maps the macroblock CBP to a codeNum using the me(v) mapping tables.
// Stage 2 builds the ue(v) Exp-Golomb codeword (value and length) from that codeNum.
// A saturating counter adds up the codeword lengths of every codeword the packer accepts.
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   in_valid/in_ready       input handshake; in_cbp {chroma[5:4], luma8x8[3:0]}, in_inter table select
//   out_valid/out_ready     output handshake
//   out_bits                codeNum+1, right-aligned; the packer emits out_len bits
//   out_len                 codeword length, 1..11
//   out_code_num            mapped codeNum
//   out_err                 the CBP is illegal for CHROMA_MODE; codeNum is forced to 0
//   cnt_clr, bit_cnt        slice-start clear and saturating sum of accepted out_len
module cbp_ue_enc #(
    parameter int CHROMA_MODE = 1,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_cbp,
    input  logic             in_inter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_bits,
    output logic [3:0]       out_len,
    output logic [5:0]       out_code_num,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bit_cnt
);

    // Inverse of the ChromaArrayType 1/2 intra column: CBP -> codeNum
    function automatic logic [5:0] map_a_intra(input logic [5:0] c);
        logic [5:0] m;
        case (c)
            6'd0:  m = 6'd3;  6'd1:  m = 6'd29; 6'd2:  m = 6'd30; 6'd3:  m = 6'd17;
            6'd4:  m = 6'd31; 6'd5:  m = 6'd18; 6'd6:  m = 6'd37; 6'd7:  m = 6'd8;
            6'd8:  m = 6'd32; 6'd9:  m = 6'd38; 6'd10: m = 6'd19; 6'd11: m = 6'd9;
            6'd12: m = 6'd20; 6'd13: m = 6'd10; 6'd14: m = 6'd11; 6'd15: m = 6'd2;
            6'd16: m = 6'd16; 6'd17: m = 6'd33; 6'd18: m = 6'd34; 6'd19: m = 6'd21;
            6'd20: m = 6'd35; 6'd21: m = 6'd22; 6'd22: m = 6'd39; 6'd23: m = 6'd4;
            6'd24: m = 6'd36; 6'd25: m = 6'd40; 6'd26: m = 6'd23; 6'd27: m = 6'd5;
            6'd28: m = 6'd24; 6'd29: m = 6'd6;  6'd30: m = 6'd7;  6'd31: m = 6'd1;
            6'd32: m = 6'd41; 6'd33: m = 6'd42; 6'd34: m = 6'd43; 6'd35: m = 6'd25;
            6'd36: m = 6'd44; 6'd37: m = 6'd26; 6'd38: m = 6'd46; 6'd39: m = 6'd12;
            6'd40: m = 6'd45; 6'd41: m = 6'd47; 6'd42: m = 6'd27; 6'd43: m = 6'd13;
            6'd44: m = 6'd28; 6'd45: m = 6'd14; 6'd46: m = 6'd15; 6'd47: m = 6'd0;
            default: m = 6'd0;
        endcase
        return m;
    endfunction

    // Inverse of the ChromaArrayType 1/2 inter column: CBP -> codeNum
    function automatic logic [5:0] map_a_inter(input logic [5:0] c);
        logic [5:0] m;
        case (c)
            6'd0:  m = 6'd0;  6'd1:  m = 6'd2;  6'd2:  m = 6'd3;  6'd3:  m = 6'd7;
            6'd4:  m = 6'd4;  6'd5:  m = 6'd8;  6'd6:  m = 6'd17; 6'd7:  m = 6'd13;
            6'd8:  m = 6'd5;  6'd9:  m = 6'd18; 6'd10: m = 6'd9;  6'd11: m = 6'd14;
            6'd12: m = 6'd10; 6'd13: m = 6'd15; 6'd14: m = 6'd16; 6'd15: m = 6'd11;
            6'd16: m = 6'd1;  6'd17: m = 6'd32; 6'd18: m = 6'd33; 6'd19: m = 6'd36;
            6'd20: m = 6'd34; 6'd21: m = 6'd37; 6'd22: m = 6'd44; 6'd23: m = 6'd40;
            6'd24: m = 6'd35; 6'd25: m = 6'd45; 6'd26: m = 6'd38; 6'd27: m = 6'd41;
            6'd28: m = 6'd39; 6'd29: m = 6'd42; 6'd30: m = 6'd43; 6'd31: m = 6'd19;
            6'd32: m = 6'd6;  6'd33: m = 6'd24; 6'd34: m = 6'd25; 6'd35: m = 6'd20;
            6'd36: m = 6'd26; 6'd37: m = 6'd21; 6'd38: m = 6'd46; 6'd39: m = 6'd28;
            6'd40: m = 6'd27; 6'd41: m = 6'd47; 6'd42: m = 6'd22; 6'd43: m = 6'd29;
            6'd44: m = 6'd23; 6'd45: m = 6'd30; 6'd46: m = 6'd31; 6'd47: m = 6'd12;
            default: m = 6'd0;
        endcase
        return m;
    endfunction

    // Inverse of the ChromaArrayType 0/3 columns (luma-only CBP); inter selects the column
    function automatic logic [5:0] map_b(input logic [3:0] c, input logic inter);
        logic [5:0] m;
        case ({inter, c})
            5'd0:  m = 6'd1;  5'd1:  m = 6'd10; 5'd2:  m = 6'd11; 5'd3:  m = 6'd6;
            5'd4:  m = 6'd12; 5'd5:  m = 6'd7;  5'd6:  m = 6'd14; 5'd7:  m = 6'd2;
            5'd8:  m = 6'd13; 5'd9:  m = 6'd15; 5'd10: m = 6'd8;  5'd11: m = 6'd3;
            5'd12: m = 6'd9;  5'd13: m = 6'd4;  5'd14: m = 6'd5;  5'd15: m = 6'd0;
            5'd16: m = 6'd0;  5'd17: m = 6'd1;  5'd18: m = 6'd2;  5'd19: m = 6'd5;
            5'd20: m = 6'd3;  5'd21: m = 6'd6;  5'd22: m = 6'd14; 5'd23: m = 6'd10;
            5'd24: m = 6'd4;  5'd25: m = 6'd15; 5'd26: m = 6'd7;  5'd27: m = 6'd11;
            5'd28: m = 6'd8;  5'd29: m = 6'd12; 5'd30: m = 6'd13; 5'd31: m = 6'd9;
            default: m = 6'd0;
        endcase
        return m;
    endfunction

    // Exp-Golomb length 2p+1, where p is the leading-one position of codeNum+1
    function automatic logic [3:0] ue_len(input logic [5:0] v);
        logic [3:0] l;
        if (v[5])      l = 4'd11;
        else if (v[4]) l = 4'd9;
        else if (v[3]) l = 4'd7;
        else if (v[2]) l = 4'd5;
        else if (v[1]) l = 4'd3;
        else           l = 4'd1;
        return l;
    endfunction

    logic             s1_valid_r;
    logic [5:0]       s1_code_num_r;
    logic             s1_err_r;
    logic [5:0]       lk_code_s;
    logic             lk_err_s;
    logic             adv_s;
    logic [5:0]       bits_s;
    logic             out_hs_s;
    logic [CNT_W:0]   sum_s;
    logic [CNT_W-1:0] sat_s;

    // Stage 2 accepts whenever it is empty or its content leaves this cycle
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = !s1_valid_r || adv_s;
    assign out_hs_s = out_valid && out_ready;
    assign bits_s   = s1_code_num_r + 6'd1;

    // CBP -> codeNum lookup with legality check for the configured chroma format
    always_comb begin
        lk_code_s = 6'd0;
        lk_err_s  = 1'b0;
        if (CHROMA_MODE != 0) begin
            if (in_cbp > 6'd47) begin
                lk_err_s = 1'b1;
            end else if (in_inter) begin
                lk_code_s = map_a_inter(in_cbp);
            end else begin
                lk_code_s = map_a_intra(in_cbp);
            end
        end else begin
            if (in_cbp[5:4] != 2'd0) begin
                lk_err_s = 1'b1;
            end else begin
                lk_code_s = map_b(in_cbp[3:0], in_inter);
            end
        end
    end

    // Saturating accumulate: an overflow into the extra MSB pins the count at all-ones
    always_comb begin
        sum_s = {1'b0, bit_cnt} + (CNT_W+1)'(out_len);
        if (sum_s[CNT_W]) begin
            sat_s = {CNT_W{1'b1}};
        end else begin
            sat_s = sum_s[CNT_W-1:0];
        end
    end

    // Stage 1 register: captures the lookup result whenever there is room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r    <= 1'b0;
            s1_code_num_r <= 6'd0;
            s1_err_r      <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_code_num_r <= lk_code_s;
                s1_err_r      <= lk_err_s;
            end
        end
    end

    // Stage 2 register: drives the outputs, which hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_bits     <= 6'd0;
            out_len      <= 4'd0;
            out_code_num <= 6'd0;
            out_err      <= 1'b0;
        end else if (adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_bits     <= bits_s;
                out_len      <= ue_len(bits_s);
                out_code_num <= s1_code_num_r;
                out_err      <= s1_err_r;
            end
        end
    end

    // Per-slice bit counter; a clear coinciding with a handshake keeps that codeword's length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            bit_cnt <= out_hs_s ? CNT_W'(out_len) : {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            bit_cnt <= sat_s;
        end
    end

endmodule

// File: tb/tb_cbp_ue_enc.sv
// Directed bench for cbp_ue_enc: instance a (CHROMA_MODE=1, CNT_W=24) and
// instance b (CHROMA_MODE=0, CNT_W=5, small so that saturation is reachable).
module tb_cbp_ue_enc;
    logic clk;
    logic rst_n;
    logic a_in_valid, a_in_ready, a_in_inter, a_out_valid, a_out_ready, a_out_err, a_cnt_clr;
    logic [5:0] a_in_cbp, a_out_bits, a_out_code_num;
    logic [3:0] a_out_len;
    logic [23:0] a_bit_cnt;
    logic b_in_valid, b_in_ready, b_in_inter, b_out_valid, b_out_ready, b_out_err, b_cnt_clr;
    logic [5:0] b_in_cbp, b_out_bits, b_out_code_num;
    logic [3:0] b_out_len;
    logic [4:0] b_bit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Forward tables codeNum -> CBP (ChromaArrayType 1/2)
    int intra_fwd [48] = '{47,31,15,0,23,27,29,30,7,11,13,14,39,43,45,46,
                           16,3,5,10,12,19,21,26,28,35,37,42,44,1,2,4,
                           8,17,18,20,24,6,9,22,25,32,33,34,36,40,38,41};
    int inter_fwd [48] = '{0,16,1,2,4,8,32,3,5,10,12,15,47,7,11,13,
                           14,6,9,31,35,37,42,44,33,34,36,40,39,43,45,46,
                           17,18,20,24,19,21,26,28,23,27,29,30,22,25,38,41};

    cbp_ue_enc #(.CHROMA_MODE(1), .CNT_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_cbp(a_in_cbp), .in_inter(a_in_inter), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_bits(a_out_bits), .out_len(a_out_len),
        .out_code_num(a_out_code_num), .out_err(a_out_err), .cnt_clr(a_cnt_clr),
        .bit_cnt(a_bit_cnt));

    cbp_ue_enc #(.CHROMA_MODE(0), .CNT_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_cbp(b_in_cbp), .in_inter(b_in_inter), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_bits(b_out_bits), .out_len(b_out_len),
        .out_code_num(b_out_code_num), .out_err(b_out_err), .cnt_clr(b_cnt_clr),
        .bit_cnt(b_bit_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_code(input bit inter, input int cbp);
        for (int k = 0; k < 48; k++) begin
            if ((inter ? inter_fwd[k] : intra_fwd[k]) == cbp) return k;
        end
        return -1;
    endfunction

    function automatic int lenf(input int code);
        int v;
        int p;
        v = code + 1;
        p = 0;
        while (v > 1) begin
            v = v >> 1;
            p++;
        end
        return 2 * p + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One isolated transfer, entered #1 after a rising edge; checks 2-edge latency and the codeword
    task automatic xfer(input bit sel_b, input logic [5:0] cbp, input bit inter,
                        input int ec, input bit ee, input string tag);
        if (sel_b) begin
            b_in_valid = 1'b1; b_in_cbp = cbp; b_in_inter = inter; b_out_ready = 1'b1;
        end else begin
            a_in_valid = 1'b1; a_in_cbp = cbp; a_in_inter = inter; a_out_ready = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk({tag, "_early"}, sel_b ? b_out_valid : a_out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, sel_b ? b_out_valid : a_out_valid, 1);
        chk({tag, "_code"}, sel_b ? b_out_code_num : a_out_code_num, ec);
        chk({tag, "_bits"}, sel_b ? b_out_bits : a_out_bits, ec + 1);
        chk({tag, "_len"}, sel_b ? b_out_len : a_out_len, lenf(ec));
        chk({tag, "_err"}, sel_b ? b_out_err : a_out_err, ee);
    endtask

    initial begin
        int sent;
        int recv;
        int first;
        int last;
        int nv;
        bit prev_stall;
        logic [5:0] h_bits;
        logic [5:0] h_code;
        logic [3:0] h_len;
        logic h_err;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_cbp = 6'd0; a_in_inter = 1'b0; a_out_ready = 1'b0; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_cbp = 6'd0; b_in_inter = 1'b0; b_out_ready = 1'b0; b_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_bits", a_out_bits, 0);
        chk("rst_out_len", a_out_len, 0);
        chk("rst_code", a_out_code_num, 0);
        chk("rst_err", a_out_err, 0);
        chk("rst_bit_cnt", a_bit_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", a_in_ready, 1);

        // T1 / T2: intra and inter lookups
        xfer(1'b0, 6'd47, 1'b0, 0, 1'b0, "t1_intra47");
        xfer(1'b0, 6'd0, 1'b0, 3, 1'b0, "t1_intra0");
        xfer(1'b0, 6'd0, 1'b1, 0, 1'b0, "t2_inter0");
        xfer(1'b0, 6'd47, 1'b1, 12, 1'b0, "t2_inter47");
        xfer(1'b0, 6'd38, 1'b0, 46, 1'b0, "t2_intra38");
        @(posedge clk); #1;
        chk("t5_sum25", a_bit_cnt, 25);

        // T5: counter clear, accumulate 1+5+11, clear with concurrent len-7 handshake
        a_cnt_clr = 1'b1;
        @(posedge clk); #1;
        a_cnt_clr = 1'b0;
        chk("t5_clr_alone", a_bit_cnt, 0);
        xfer(1'b0, 6'd47, 1'b0, 0, 1'b0, "t5_l1");
        xfer(1'b0, 6'd0, 1'b0, 3, 1'b0, "t5_l5");
        xfer(1'b0, 6'd38, 1'b0, 46, 1'b0, "t5_l11");
        @(posedge clk); #1;
        chk("t5_sum17", a_bit_cnt, 17);
        xfer(1'b0, 6'd47, 1'b1, 12, 1'b0, "t5_l7");
        a_cnt_clr = 1'b1;
        @(posedge clk); #1;
        a_cnt_clr = 1'b0;
        chk("t5_clr_hs", a_bit_cnt, 7);

        // T4: illegal CBPs and the luma-only tables
        xfer(1'b0, 6'd48, 1'b0, 0, 1'b1, "t4_a48");
        xfer(1'b0, 6'd63, 1'b1, 0, 1'b1, "t4_a63");
        xfer(1'b1, 6'h10, 1'b0, 0, 1'b1, "t4_b10");
        xfer(1'b1, 6'd15, 1'b0, 0, 1'b0, "t4_b_intra15");
        xfer(1'b1, 6'd0, 1'b1, 0, 1'b0, "t4_b_inter0");
        xfer(1'b1, 6'd15, 1'b1, 9, 1'b0, "t4_b_inter15");
        @(posedge clk); #1;
        chk("t4_b_sum10", b_bit_cnt, 10);
        b_cnt_clr = 1'b1;
        @(posedge clk); #1;
        b_cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) xfer(1'b1, 6'd9, 1'b0, 15, 1'b0, "t5_b_sat");
        @(posedge clk); #1;
        chk("t5_saturate", b_bit_cnt, 31);

        // T3: 48 intra CBPs with random backpressure
        sent = 0; recv = 0; prev_stall = 1'b0;
        h_bits = 6'd0; h_code = 6'd0; h_len = 4'd0; h_err = 1'b0;
        for (int cyc = 0; cyc < 600 && recv < 48; cyc++) begin
            @(posedge clk); #1;
            a_in_valid = (sent < 48);
            a_in_cbp = sent[5:0];
            a_in_inter = 1'b0;
            a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                chk("t3_hold_valid", a_out_valid, 1);
                chk("t3_hold_bits", a_out_bits, h_bits);
                chk("t3_hold_code", a_out_code_num, h_code);
                chk("t3_hold_len", a_out_len, h_len);
                chk("t3_hold_err", a_out_err, h_err);
            end
            if (a_out_valid && a_out_ready) begin
                chk("t3_code", a_out_code_num, exp_code(1'b0, recv));
                chk("t3_bits", a_out_bits, exp_code(1'b0, recv) + 1);
                chk("t3_len", a_out_len, lenf(exp_code(1'b0, recv)));
                recv++;
            end
            if (a_in_valid && a_in_ready) sent++;
            prev_stall = a_out_valid && !a_out_ready;
            h_bits = a_out_bits; h_code = a_out_code_num; h_len = a_out_len; h_err = a_out_err;
        end
        chk("t3_count", recv, 48);

        // T3: continuous ready gives one output per cycle
        a_out_ready = 1'b1;
        sent = 0; nv = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            a_in_valid = (sent < 8);
            a_in_cbp = 6'(40 + sent);
            a_in_inter = 1'b1;
            @(negedge clk);
            if (a_in_valid && a_in_ready) sent++;
            if (a_out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                chk("t3_tput_code", a_out_code_num, exp_code(1'b1, 40 + nv));
                nv++;
            end
        end
        chk("t3_tput_n", nv, 8);
        chk("t3_tput_span", last - first, 7);

        // T6: reset with both stages full
        a_out_ready = 1'b0;
        a_in_inter = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_cbp = 6'd5;
        @(posedge clk); #1;
        a_in_cbp = 6'd6;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("t6_full_valid", a_out_valid, 1);
        chk("t6_full_ready", a_in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", a_out_valid, 0);
        chk("t6_bits", a_out_bits, 0);
        chk("t6_len", a_out_len, 0);
        chk("t6_code", a_out_code_num, 0);
        chk("t6_cnt", a_bit_cnt, 0);
        chk("t6_in_ready", a_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 6'd7, 1'b0, 8, 1'b0, "t6_next");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
